// File: rtl/alu_arbiter_pkg.sv
// Shared types and widths for the two-requester ALU arbiter.
// The latency helper folds an out-of-range ALU_LATENCY into the 1..15 counter range.
package alu_arbiter_pkg;
    localparam int OPCODE_W = 4;
    localparam int DATA_W   = 32;
    localparam int CNT_W    = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic [CNT_W-1:0] eff_latency(input int lat);
        if (lat < 1) return CNT_W'(1);
        if (lat > 15) return CNT_W'(15);
        return CNT_W'(lat);
    endfunction
endpackage

// File: rtl/alu_arbiter_if.sv
// Request, response and ALU-side bundle of the arbiter.
// Handshakes: a transfer happens on a rising edge where valid && ready; the payload is held while valid waits.
interface alu_arbiter_if import alu_arbiter_pkg::*; ();
    logic                req0_valid;
    logic                req0_ready;
    logic [OPCODE_W-1:0] req0_opcode;
    logic [DATA_W-1:0]   req0_a;
    logic [DATA_W-1:0]   req0_b;

    logic                req1_valid;
    logic                req1_ready;
    logic [OPCODE_W-1:0] req1_opcode;
    logic [DATA_W-1:0]   req1_a;
    logic [DATA_W-1:0]   req1_b;

    logic                rsp_valid;
    logic                rsp_ready;
    logic                rsp_id;
    logic [DATA_W-1:0]   rsp_result;

    logic [OPCODE_W-1:0] alu_opcode;
    logic [DATA_W-1:0]   alu_a;
    logic [DATA_W-1:0]   alu_b;
    logic [DATA_W-1:0]   alu_result;

    modport slave (
        input  req0_valid, req0_opcode, req0_a, req0_b,
        output req0_ready,
        input  req1_valid, req1_opcode, req1_a, req1_b,
        output req1_ready,
        output rsp_valid, rsp_id, rsp_result,
        input  rsp_ready,
        output alu_opcode, alu_a, alu_b,
        input  alu_result
    );

    modport master (
        output req0_valid, req0_opcode, req0_a, req0_b,
        input  req0_ready,
        output req1_valid, req1_opcode, req1_a, req1_b,
        input  req1_ready,
        input  rsp_valid, rsp_id, rsp_result,
        output rsp_ready,
        input  alu_opcode, alu_a, alu_b,
        output alu_result
    );
endinterface

// File: rtl/alu_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick: on a tie the requester not granted last wins.
module rr_arb2 (
    input  logic valid0,
    input  logic valid1,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_id
);
    always_comb begin
        grant_valid = valid0 | valid1;
        if (valid0 && valid1) grant_id = ~last_grant;
        else                  grant_id = valid1;
    end
endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one external combinational ALU, holds the operands for
// ALU_LATENCY cycles, then presents the captured result until the consumer takes it.
module alu_arbiter import alu_arbiter_pkg::*; #(
    parameter int ALU_LATENCY = 1
) (
    input  logic          clk,
    input  logic          rst,
    alu_arbiter_if.slave  bus,
    output state_t        state_dbg
);
    localparam logic [CNT_W-1:0] LOAD = eff_latency(ALU_LATENCY);

    state_t              state, state_nx;
    logic                grant_valid, grant_id;
    logic                last_grant;
    logic                ready0, ready1;
    logic                accept, done, rsp_fire;
    logic [CNT_W-1:0]    cnt;
    logic [OPCODE_W-1:0] op_q;
    logic [DATA_W-1:0]   a_q, b_q, result_q;
    logic                id_q, rsp_valid_q;

    rr_arb2 u_rr_arb2 (
        .valid0      (bus.req0_valid),
        .valid1      (bus.req1_valid),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        ready0   = 1'b0;
        ready1   = 1'b0;
        accept   = 1'b0;
        done     = 1'b0;
        rsp_fire = 1'b0;
        case (state)
            IDLE: begin
                // Ready is gated by rst so nothing is offered during the reset cycle.
                if (!rst && grant_valid) begin
                    ready0   = ~grant_id;
                    ready1   = grant_id;
                    accept   = 1'b1;
                    state_nx = EXEC;
                end
            end
            EXEC: begin
                if (cnt <= CNT_W'(1)) begin
                    done     = 1'b1;
                    state_nx = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_fire = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            id_q        <= 1'b0;
            cnt         <= '0;
            last_grant  <= 1'b1;
            result_q    <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            if (accept) begin
                op_q       <= grant_id ? bus.req1_opcode : bus.req0_opcode;
                a_q        <= grant_id ? bus.req1_a      : bus.req0_a;
                b_q        <= grant_id ? bus.req1_b      : bus.req0_b;
                id_q       <= grant_id;
                cnt        <= LOAD;
                last_grant <= grant_id;
            end
            if (state == EXEC) cnt <= cnt - CNT_W'(1);
            if (done) begin
                result_q    <= bus.alu_result;
                rsp_valid_q <= 1'b1;
            end
            if (rsp_fire) rsp_valid_q <= 1'b0;
        end
    end

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;
    assign bus.alu_opcode = op_q;
    assign bus.alu_a      = a_q;
    assign bus.alu_b      = b_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = id_q;
    assign bus.rsp_result = result_q;
    assign state_dbg      = state;
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter: ALU_LATENCY, 1, number of cycles (1..15) latched operands are held on the ALU port before the result is captured.
REQ-002 SHALL have one clock and a synchronous, active-high reset on ports clk and rst.
REQ-003 SHALL have port: clk  input  1  rising-edge clock.
REQ-004 SHALL have port: rst  input  1  synchronous active-high reset.
REQ-005 SHALL have ports: req0_valid  input  1, req0_ready  output  1, req0_opcode  input  4, req0_a  input  32, req0_b  input  32; requester 0 operation request.
REQ-006 SHALL have ports req1_valid, req1_ready, req1_opcode, req1_a and req1_b, identical in direction and width to requester 0; requester 1 operation request.
REQ-007 SHALL have ports: rsp_valid  output  1, rsp_ready  input  1, rsp_id  output  1 (requester index), rsp_result  output  32.
REQ-008 SHALL have ports: alu_opcode  output  4, alu_a  output  32, alu_b  output  32, alu_result  input  32; connection to the combinational alu.

Function
REQ-009 SHALL implement FSM states IDLE, EXEC and RESP.
REQ-010 In IDLE, reqN_ready SHALL be 1 only for the requester granted this cycle; it SHALL be 0 in all other states.
REQ-011 Grant: only one valid requester -> that requester; both valid -> the requester not granted last; neither valid -> none.
REQ-012 Acceptance SHALL occur on an edge where reqN_valid && reqN_ready: latch opcode, a, b and id; load down-counter with ALU_LATENCY; go to EXEC; update last_grant.
REQ-013 alu_opcode, alu_a and alu_b SHALL be driven from the latched registers at all times, holding their values outside EXEC.
REQ-014 EXEC SHALL decrement the counter each cycle; on the edge where the counter equals 1, it SHALL capture alu_result into rsp_result and go to RESP.
REQ-015 Latency: with acceptance at edge E0, rsp_valid SHALL rise after edge E0+ALU_LATENCY.
REQ-016 In RESP, rsp_valid SHALL be 1, and rsp_result and rsp_id SHALL be stable until rsp_ready is sampled 1.
REQ-017 On the edge with rsp_valid && rsp_ready, it SHALL clear rsp_valid and return to IDLE.
REQ-018 The earliest next acceptance SHALL be the following edge (no same-cycle response/accept overlap).
REQ-019 Opcode SHALL pass through unmodified; opcode semantics, including values 8..15, belong to the alu.
REQ-020 A requester that deasserts valid before grant SHALL lose no state; input changes during EXEC/RESP SHALL be ignored.
REQ-021 An out-of-range ALU_LATENCY of 0 SHALL behave as 1.

Reset
REQ-022 On rst: state IDLE; rsp_valid 0, rsp_id 0, rsp_result 0; latched opcode/a/b 0; counter 0; last_grant 1 (requester 0 wins the first tie); both ready 0 during the reset cycle.
REQ-023 Reset asserted in EXEC or RESP SHALL abandon the transaction with no response emitted afterwards.

Structure
REQ-024 A shared package alu_arbiter_pkg SHALL hold the state encodings (IDLE=0, EXEC=1, RESP=2), OPCODE_W=4 and DATA_W=32.
REQ-025 One sub-module rr_arb2 SHALL provide the combinational two-way round-robin pick (inputs: two valids and last_grant; outputs: grant_valid and grant_id).
REQ-026 The alu SHALL be instantiated outside this block, at the top level.

Verification
The bench models alu_result = alu_a ^ alu_b; ALU_LATENCY=1 unless noted.
REQ-027 Single request: req0 with opcode 2, a=101010101, b=11, rsp_ready=1 -> req0_ready 1 in IDLE; rsp_valid one cycle after acceptance; rsp_id 0; rsp_result=101010101^11.
REQ-028 Tie fairness: both requesters held valid for 4 transactions -> grants alternate 0,1,0,1; each rsp_id matches its operands.
REQ-029 Back-pressure: rsp_ready=0 for 5 cycles -> rsp_valid, rsp_result and rsp_id stable; both ready 0; completes on the first rsp_ready=1 edge.
REQ-030 ALU_LATENCY=3: accept at edge E0 -> alu_a and alu_b stable through E0+3; rsp_valid rises after E0+3; result correct.
REQ-031 Reset in EXEC: rst pulsed one cycle during EXEC -> rsp_valid stays 0; all outputs at reset values; a subsequent req1-only request is served with rsp_id 1.
REQ-032 Change during EXEC: req1 operands changed during EXEC -> response reflects the originally accepted operands.
